// File: rtl/uart_rx_baud_gen_pkg.sv
// Shared definitions for the UART receive front end: FSM states, divisor limits, frame length.
// Latency: n/a; backpressure: n/a.
package uart_rx_baud_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUN     = 2'd2,
    WAIT_HI = 2'd3
  } rx_state_t;

  localparam int CNT_W_DEF    = 20;
  localparam int MIN_BAUD_DEF = 15;

  // Bit count after the stop pulse, and the count seen while the stop pulse fires.
  localparam logic [9:0] STOP_CNT = 10'd10;
  localparam logic [9:0] LAST_CNT = STOP_CNT - 10'd1;

endpackage

// File: rtl/uart_rx_baud_gen_sync.sv
// Multi-flop synchroniser for the idle-high serial line; flops reset to 1.
// Latency: STAGES clks; backpressure: none.
module uart_rx_baud_gen_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_baud_gen.sv
// UART rx front end: start detect, bit-centre baud_clk pulses, rx_en framing, start/stop checks.
// Latency: first pulse (baud>>1) clks after detect, then every per_q; backpressure: none.
module uart_rx_baud_gen
  import uart_rx_baud_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MIN_BAUD    = MIN_BAUD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [CNT_W-1:0] baud,
  input  logic             rxd,
  input  logic [9:0]       bit_cnt,
  output logic             rx_en,
  output logic             baud_clk,
  output logic             rx_bit,
  output logic             busy,
  output logic             start_err,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] MIN_BAUD_C = CNT_W'(MIN_BAUD);

  logic             rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_q;
  logic             stop_bad;

  uart_rx_baud_gen_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rxd),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      per_q     <= '0;
      stop_bad  <= 1'b0;
      rx_en     <= 1'b0;
      baud_clk  <= 1'b0;
      rx_bit    <= 1'b0;
      busy      <= 1'b0;
      start_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      baud_clk  <= 1'b0;
      start_err <= 1'b0;
      frame_err <= 1'b0;
      // Standby or an illegal divisor aborts silently, even mid-frame.
      if (!sel || (baud < MIN_BAUD_C)) begin
        state    <= IDLE;
        cnt      <= '0;
        stop_bad <= 1'b0;
        rx_en    <= 1'b0;
        rx_bit   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              per_q    <= baud;
              cnt      <= (baud >> 1) - 1'b1;
              stop_bad <= 1'b0;
              state    <= START;
              rx_en    <= 1'b1;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (cnt == '0) begin
              if (rxs) begin
                start_err <= 1'b1;
                state     <= IDLE;
                rx_en     <= 1'b0;
                busy      <= 1'b0;
              end else begin
                baud_clk <= 1'b1;
                rx_bit   <= 1'b0;
                cnt      <= per_q - 1'b1;
                state    <= RUN;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RUN: begin
            // The counter reaches STOP_CNT the clk after the stop pulse.
            if (bit_cnt == STOP_CNT) begin
              rx_en <= 1'b0;
              cnt   <= '0;
              if (stop_bad) begin
                state <= WAIT_HI;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (cnt == '0) begin
              baud_clk <= 1'b1;
              rx_bit   <= rxs;
              cnt      <= per_q - 1'b1;
              if ((bit_cnt == LAST_CNT) && !rxs) begin
                frame_err <= 1'b1;
                stop_bad  <= 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          WAIT_HI: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            rx_en <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_baud_gen.sv
// Self-checking bench for uart_rx_baud_gen: table-driven frames, corner sequences, random frames.
// Line timing and expected pulses come from bit-period arithmetic, not from the RTL structure.
module tb_uart_rx_baud_gen;

  localparam int SYNC  = 2;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sel = 1'b1;
  logic [CNT_W-1:0] baud = 20'd16;
  logic             rxd = 1'b1;
  logic [9:0]       bit_cnt;
  logic             rx_en, baud_clk, rx_bit, busy, start_err, frame_err;

  uart_rx_baud_gen #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CNT_W),
    .MIN_BAUD   (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .baud     (baud),
    .rxd      (rxd),
    .bit_cnt  (bit_cnt),
    .rx_en    (rx_en),
    .baud_clk (baud_clk),
    .rx_bit   (rx_bit),
    .busy     (busy),
    .start_err(start_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream bit counter: counts pulses while rx_en, cleared when rx_en is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         bit_cnt <= 10'd0;
    else if (!rx_en)                    bit_cnt <= 10'd0;
    else if (baud_clk && bit_cnt < 10)  bit_cnt <= bit_cnt + 10'd1;
  end

  int   checks = 0;
  int   errors = 0;
  int   p_cyc[$];
  logic p_bit[$];
  int   fe_cyc[$];
  int   se_cyc[$];
  int   en_first = -1;
  int   en_last = -1;
  int   viol = 0;
  logic prev_bclk = 1'b0;
  logic busy_mid = 1'b0;

  always @(negedge clk) begin
    if (baud_clk) begin
      p_cyc.push_back(cyc);
      p_bit.push_back(rx_bit);
    end
    if (frame_err) fe_cyc.push_back(cyc);
    if (start_err) se_cyc.push_back(cyc);
    if (rx_en) begin
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (baud_clk && prev_bclk) viol++;
    if (start_err && (baud_clk || frame_err)) viol++;
    if (frame_err && !baud_clk) viol++;
    prev_bclk = baud_clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    p_cyc.delete();
    p_bit.delete();
    fe_cyc.delete();
    se_cyc.delete();
    en_first = -1;
    en_last  = -1;
  endtask

  // Drives start, 8 data bits LSB first and stop, each b clks; optional extra low hold.
  task automatic drive_frame(input int b, input logic [7:0] d, input logic stop,
                             input int hold, output int c);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      repeat (b) @(negedge clk);
    end
    if (hold > 0) begin
      rxd = 1'b0;
      repeat (hold) @(negedge clk);
      busy_mid = busy;
    end
    rxd = 1'b1;
  endtask

  // Pulse k lands at the centre of bit k: detect is SYNC+1 clks after the fall.
  task automatic check_frame(input string nm, input int c, input int b,
                             input logic [9:0] eb, input int ef);
    int n;
    n = p_cyc.size();
    chk($sformatf("%s npulse", nm), n, 10);
    for (int k = 0; k < n && k < 10; k++) begin
      chk($sformatf("%s pulse%0d_cyc", nm, k), p_cyc[k], c + SYNC + 1 + (b / 2) + k * b);
      chk($sformatf("%s pulse%0d_bit", nm, k), p_bit[k], eb[k]);
    end
    chk($sformatf("%s nferr", nm), fe_cyc.size(), ef);
    if (ef > 0 && fe_cyc.size() > 0 && n >= 10)
      chk($sformatf("%s ferr_on_stop", nm), fe_cyc[0], p_cyc[9]);
    chk($sformatf("%s nserr", nm), se_cyc.size(), 0);
    chk($sformatf("%s en_first", nm), en_first, c + SYNC + 1);
    if (n >= 10) chk($sformatf("%s en_last", nm), en_last, p_cyc[9] + 1);
    chk($sformatf("%s idle_after", nm), {busy, rx_en}, 0);
  endtask

  task automatic run_case(input string nm, input int b, input logic [7:0] d,
                          input logic stop, input int hold,
                          input logic [9:0] eb, input int ef);
    int c;
    baud = CNT_W'(b);
    clear_mon();
    busy_mid = 1'b0;
    drive_frame(b, d, stop, hold, c);
    repeat (b + 8) @(negedge clk);
    check_frame(nm, c, b, eb, ef);
    if (hold > 0) chk($sformatf("%s busy_in_break", nm), busy_mid, 1);
  endtask

  task automatic wait_pulses(input int n, input int lim, input string nm);
    int t;
    t = 0;
    while (p_cyc.size() < n && t < lim) begin
      @(posedge clk);
      t++;
    end
    chk(nm, (p_cyc.size() >= n) ? 1 : 0, 1);
  endtask

  typedef struct {
    string      nm;
    int         b;
    logic [7:0] d;
    logic       stop;
    int         hold;
    logic [9:0] exp_bits;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int         c0;
    int         b;
    logic [7:0] d;
    logic       st;

    vecs[0] = '{"f55_b16",  16, 8'h55, 1'b1, 0,   10'b1010101010, 0};
    vecs[1] = '{"fA3_b15",  15, 8'hA3, 1'b1, 0,   10'b1101000110, 0};
    vecs[2] = '{"break_b20", 20, 8'h00, 1'b0, 100, 10'b0000000000, 1};
    vecs[3] = '{"fFF_b33",  33, 8'hFF, 1'b1, 0,   10'b1111111110, 0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_en, baud_clk, rx_bit, busy, start_err, frame_err}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_case(vecs[i].nm, vecs[i].b, vecs[i].d, vecs[i].stop, vecs[i].hold,
               vecs[i].exp_bits, vecs[i].exp_ferr);

    // False start: 4-clk glitch.
    baud = 20'd16;
    clear_mon();
    @(negedge clk);
    c0 = cyc;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("false_start nserr", se_cyc.size(), 1);
    if (se_cyc.size() > 0) chk("false_start serr_cyc", se_cyc[0], c0 + SYNC + 1 + 8);
    chk("false_start npulse", p_cyc.size(), 0);
    chk("false_start en_first", en_first, c0 + SYNC + 1);
    chk("false_start en_last", en_last, c0 + SYNC + 1 + 7);
    chk("false_start busy", busy, 0);

    // Illegal divisor: line activity ignored entirely.
    baud = 20'd14;
    clear_mon();
    drive_frame(14, 8'h00, 1'b1, 0, c0);
    repeat (20) @(negedge clk);
    chk("baud14 npulse", p_cyc.size(), 0);
    chk("baud14 en_first", en_first, -1);
    chk("baud14 busy", busy, 0);
    run_case("after_baud14_b15", 15, 8'h5A, 1'b1, 0, 10'b1010110100, 0);

    // Standby mid-frame.
    baud = 20'd16;
    clear_mon();
    fork
      drive_frame(16, 8'h00, 1'b1, 0, c0);
      begin
        wait_pulses(3, 200, "sel_wait_pulse3");
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        chk("sel_off rx_en", rx_en, 0);
        chk("sel_off busy", busy, 0);
      end
    join
    repeat (30) @(negedge clk);
    sel = 1'b1;
    repeat (30) @(negedge clk);
    chk("sel_off npulse", p_cyc.size(), 3);
    chk("sel_off nserr", se_cyc.size(), 0);

    // Divisor change mid-frame takes effect on the next frame only.
    baud = 20'd16;
    clear_mon();
    fork
      drive_frame(16, 8'h96, 1'b1, 0, c0);
      begin
        wait_pulses(3, 200, "div_wait_pulse3");
        @(negedge clk);
        baud = 20'd32;
      end
    join
    repeat (24) @(negedge clk);
    check_frame("div_change_old16", c0, 16, 10'b1100101100, 0);
    run_case("div_change_new32", 32, 8'h96, 1'b1, 0, 10'b1100101100, 0);

    // Asynchronous reset mid-frame.
    baud = 20'd16;
    clear_mon();
    fork
      drive_frame(16, 8'hFF, 1'b1, 0, c0);
      begin
        wait_pulses(5, 300, "rst_wait_pulse5");
        #3 rst_n = 1'b0;
        #1 chk("async_rst outputs", {rx_en, baud_clk, rx_bit, busy, start_err, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    chk("async_rst idle", {busy, rx_en}, 0);
    run_case("post_reset_3C", 16, 8'h3C, 1'b1, 0, 10'b1001111000, 0);

    // Random frames: divisor, data and stop-bit validity.
    for (int r = 0; r < 6; r++) begin
      b  = int'($urandom_range(15, 40));
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      run_case($sformatf("rand%0d_b%0d_d%02h", r, b, d), b, d, st, 0,
               {st, d, 1'b0}, st ? 0 : 1);
    end

    chk("pulse_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
